// File: rtl/ahb_pkg.sv
// Shared definitions for the 2-master / 4-slave AHB fabric: transfer encodings,
// master index type and the arbiter grant encoding.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int unsigned AHB_NUM_MASTERS = 2;

    typedef logic ahb_mst_t;

    // The state encoding is the one-hot grant vector itself: bit 0 = master 1.
    typedef enum logic [1:0] {
        OWN_M1 = 2'b01,
        OWN_M2 = 2'b10
    } arb_state_t;

    function automatic logic isArbPoint(input logic [1:0] trans, input logic ready);
        return ready && (trans == HTRANS_IDLE || trans == HTRANS_NONSEQ);
    endfunction

endpackage

// File: rtl/ahb_arb_tenure_cnt.sv
// Saturating, clearable count of completed transfers held by the current owner;
// limit_hit_o tells the arbiter the owner has used up its tenure.
module ahb_arb_tenure_cnt
    import ahb_pkg::*;
#(
    parameter int unsigned LIMIT = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [7:0] count_o,
    output logic       limit_hit_o
);

    localparam logic [7:0] LIMIT_C = 8'(LIMIT);

    logic [7:0] count_q;

    // A clear on an ownership change wins over a transfer completing on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q < LIMIT_C)) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign count_o     = count_q;
    assign limit_hit_o = (count_q >= LIMIT_C);

endmodule

// File: rtl/ahb_arbiter_2m.sv
// Two-master AHB arbiter: round-robin with bounded tenure and default-master parking.
// Locked transfers (hlock_1/hlock_2, hmastlock) are built only with AHB_ARB_LOCK_EN.
module ahb_arbiter_2m
    import ahb_pkg::*;
#(
    parameter int unsigned MAX_TENURE     = 8,
    parameter int unsigned DEFAULT_MASTER = 1
) (
    input  logic       hclk,
    input  logic       hreset,
    input  logic       hbusreq_1,
    input  logic       hbusreq_2,
`ifdef AHB_ARB_LOCK_EN
    input  logic       hlock_1,
    input  logic       hlock_2,
`endif
    input  logic [1:0] htrans,
    input  logic       hready,
    output logic       hgrant_1,
    output logic       hgrant_2,
    output logic       hmaster,
    output logic       hmaster_data,
    output logic       hmastlock
);

    localparam arb_state_t PARK_STATE = (DEFAULT_MASTER == 2) ? OWN_M2 : OWN_M1;
    localparam ahb_mst_t   PARK_IDX   = (DEFAULT_MASTER == 2) ? 1'b1 : 1'b0;

    arb_state_t grant_q, grant_d;
    ahb_mst_t   last_q, last_d;
    logic       parked_q, parked_d;
    ahb_mst_t   hmaster_q, hmasterData_q;

    logic       arbPoint;
    logic       ownerIsM2;
    ahb_mst_t   ownerIdx;
    logic       ownerReq;
    logic       ownerLocked;
    logic       ownerLockReq;
    logic       limitHit;
    logic       ownerChange;
    logic [7:0] tenureCount;

    assign arbPoint  = isArbPoint(htrans, hready);
    assign ownerIsM2 = (grant_q == OWN_M2);
    assign ownerIdx  = ownerIsM2;
    assign ownerReq  = ownerIsM2 ? hbusreq_2 : hbusreq_1;

`ifdef AHB_ARB_LOCK_EN
    assign ownerLockReq = ownerIsM2 ? hlock_2 : hlock_1;
    assign ownerLocked  = ownerReq && ownerLockReq;
`else
    assign ownerLockReq = 1'b0;
    assign ownerLocked  = 1'b0;
`endif

    // A parked owner has no tenure to defend, so a fresh request pair from
    // parking is settled purely by the round-robin pointer.
    always_comb begin
        grant_d  = grant_q;
        last_d   = last_q;
        parked_d = parked_q;
        if (arbPoint) begin
            if (ownerLocked || (ownerReq && !parked_q && !limitHit)) begin
                parked_d = 1'b0;
                last_d   = ownerIdx;
            end else if (hbusreq_1 && hbusreq_2) begin
                grant_d  = last_q ? OWN_M1 : OWN_M2;
                last_d   = ~last_q;
                parked_d = 1'b0;
            end else if (hbusreq_1) begin
                grant_d  = OWN_M1;
                last_d   = 1'b0;
                parked_d = 1'b0;
            end else if (hbusreq_2) begin
                grant_d  = OWN_M2;
                last_d   = 1'b1;
                parked_d = 1'b0;
            end else begin
                grant_d  = PARK_STATE;
                parked_d = 1'b1;
            end
        end
    end

    assign ownerChange = (grant_d != grant_q);

    ahb_arb_tenure_cnt #(
        .LIMIT(MAX_TENURE)
    ) u_tenure (
        .clk_i      (hclk),
        .rst_i      (hreset),
        .inc_i      (hready && htrans[1]),
        .clr_i      (ownerChange),
        .count_o    (tenureCount),
        .limit_hit_o(limitHit)
    );

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            grant_q       <= PARK_STATE;
            last_q        <= 1'b1;
            parked_q      <= 1'b1;
            hmaster_q     <= PARK_IDX;
            hmasterData_q <= PARK_IDX;
        end else begin
            grant_q  <= grant_d;
            last_q   <= last_d;
            parked_q <= parked_d;
            if (hready) begin
                hmaster_q     <= ownerIdx;
                hmasterData_q <= hmaster_q;
            end
        end
    end

`ifdef AHB_ARB_LOCK_EN
    logic hmastlock_q;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            hmastlock_q <= 1'b0;
        end else if (hready) begin
            hmastlock_q <= ownerLockReq;
        end
    end

    assign hmastlock = hmastlock_q;
`else
    assign hmastlock = ownerLockReq;
`endif

    assign hgrant_1     = grant_q[0];
    assign hgrant_2     = grant_q[1];
    assign hmaster      = hmaster_q;
    assign hmaster_data = hmasterData_q;

endmodule

// File: tb/tb_ahb_arbiter_2m.sv
// Bench for ahb_arbiter_2m (MAX_TENURE=4, DEFAULT_MASTER=1); lock sequence only with AHB_ARB_LOCK_EN.
module tb_ahb_arbiter_2m;
    import ahb_pkg::*;

    logic       hclk = 1'b0;
    logic       hreset;
    logic       hbusreq_1, hbusreq_2;
`ifdef AHB_ARB_LOCK_EN
    logic       hlock_1, hlock_2;
`endif
    logic [1:0] htrans;
    logic       hready;
    logic       hgrant_1, hgrant_2, hmaster, hmaster_data, hmastlock;
    logic [3:0] outBus;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       req1;
        logic       req2;
        logic [1:0] trans;
        logic       rdy;
        logic [3:0] expOut;
        logic [7:0] expCnt;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] expOut;
        logic [7:0] expCnt;
    } exp_t;

    vec_t vecs[31];
    exp_t expQ[$];

    ahb_arbiter_2m #(
        .MAX_TENURE    (4),
        .DEFAULT_MASTER(1)
    ) dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .hbusreq_1   (hbusreq_1),
        .hbusreq_2   (hbusreq_2),
`ifdef AHB_ARB_LOCK_EN
        .hlock_1     (hlock_1),
        .hlock_2     (hlock_2),
`endif
        .htrans      (htrans),
        .hready      (hready),
        .hgrant_1    (hgrant_1),
        .hgrant_2    (hgrant_2),
        .hmaster     (hmaster),
        .hmaster_data(hmaster_data),
        .hmastlock   (hmastlock)
    );

    always #5 hclk = ~hclk;

    assign outBus = {hgrant_1, hgrant_2, hmaster, hmaster_data};

    task automatic compareValue(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic driveBus(input logic r1, input logic r2, input logic [1:0] trans, input logic rdy);
        @(negedge hclk);
        hbusreq_1 = r1;
        hbusreq_2 = r2;
        htrans    = trans;
        hready    = rdy;
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        driveBus(v.req1, v.req2, v.trans, v.rdy);
        expQ.push_back('{name, v.expOut, v.expCnt});
        @(posedge hclk);
        #1;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard actual=empty required=entry");
        end else begin
            e = expQ.pop_front();
            compareValue({e.name, "_out"}, {4'h0, outBus}, {4'h0, e.expOut});
            compareValue({e.name, "_cnt"}, dut.tenureCount, e.expCnt);
            compareValue({e.name, "_lock"}, {7'h0, hmastlock}, 8'h00);
        end
    endtask

    task automatic doReset();
        @(negedge hclk);
        hreset = 1'b1;
        repeat (2) @(negedge hclk);
        hreset = 1'b0;
    endtask

    initial begin
        hreset    = 1'b1;
        hbusreq_1 = 1'b0;
        hbusreq_2 = 1'b0;
        htrans    = HTRANS_IDLE;
        hready    = 1'b1;
`ifdef AHB_ARB_LOCK_EN
        hlock_1   = 1'b0;
        hlock_2   = 1'b0;
`endif

        // {req1, req2, htrans, hready, {g1,g2,hmaster,hmaster_data}, tenure count after the edge}
        vecs[0]  = '{1'b0, 1'b0, HTRANS_IDLE,   1'b1, 4'b1000, 8'd0};
        vecs[1]  = '{1'b1, 1'b1, HTRANS_IDLE,   1'b1, 4'b1000, 8'd0};
        vecs[2]  = '{1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, 4'b1000, 8'd1};
        vecs[3]  = '{1'b1, 1'b1, HTRANS_SEQ,    1'b1, 4'b1000, 8'd2};
        vecs[4]  = '{1'b1, 1'b1, HTRANS_SEQ,    1'b1, 4'b1000, 8'd3};
        vecs[5]  = '{1'b1, 1'b1, HTRANS_SEQ,    1'b1, 4'b1000, 8'd4};
        vecs[6]  = '{1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, 4'b0100, 8'd0};
        vecs[7]  = '{1'b1, 1'b1, HTRANS_IDLE,   1'b1, 4'b0110, 8'd0};
        vecs[8]  = '{1'b1, 1'b1, HTRANS_IDLE,   1'b1, 4'b0111, 8'd0};
        vecs[9]  = '{1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, 4'b0111, 8'd1};
        vecs[10] = '{1'b1, 1'b0, HTRANS_NONSEQ, 1'b0, 4'b0111, 8'd1};
        vecs[11] = '{1'b1, 1'b0, HTRANS_NONSEQ, 1'b0, 4'b0111, 8'd1};
        vecs[12] = '{1'b1, 1'b0, HTRANS_NONSEQ, 1'b0, 4'b0111, 8'd1};
        vecs[13] = '{1'b1, 1'b0, HTRANS_NONSEQ, 1'b1, 4'b1011, 8'd0};
        vecs[14] = '{1'b1, 1'b0, HTRANS_IDLE,   1'b1, 4'b1001, 8'd0};
        vecs[15] = '{1'b0, 1'b0, HTRANS_IDLE,   1'b1, 4'b1000, 8'd0};
        vecs[16] = '{1'b0, 1'b1, HTRANS_IDLE,   1'b1, 4'b0100, 8'd0};
        vecs[17] = '{1'b0, 1'b1, HTRANS_IDLE,   1'b1, 4'b0110, 8'd0};
        vecs[18] = '{1'b0, 1'b0, HTRANS_IDLE,   1'b1, 4'b1011, 8'd0};
        vecs[19] = '{1'b0, 1'b0, HTRANS_IDLE,   1'b1, 4'b1001, 8'd0};
        vecs[20] = '{1'b0, 1'b1, HTRANS_BUSY,   1'b1, 4'b1000, 8'd0};
        vecs[21] = '{1'b0, 1'b1, HTRANS_IDLE,   1'b1, 4'b0100, 8'd0};
        vecs[22] = '{1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, 4'b0110, 8'd1};
        vecs[23] = '{1'b0, 1'b1, HTRANS_SEQ,    1'b1, 4'b0111, 8'd2};
        vecs[24] = '{1'b0, 1'b1, HTRANS_SEQ,    1'b1, 4'b0111, 8'd3};
        vecs[25] = '{1'b0, 1'b1, HTRANS_SEQ,    1'b1, 4'b0111, 8'd4};
        vecs[26] = '{1'b0, 1'b1, HTRANS_SEQ,    1'b1, 4'b0111, 8'd4};
        vecs[27] = '{1'b0, 1'b1, HTRANS_SEQ,    1'b1, 4'b0111, 8'd4};
        vecs[28] = '{1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, 4'b0111, 8'd4};
        vecs[29] = '{1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, 4'b1011, 8'd0};
        vecs[30] = '{1'b1, 1'b0, HTRANS_IDLE,   1'b1, 4'b1001, 8'd0};

        repeat (2) @(negedge hclk);
        hreset = 1'b0;
        #1;
        compareValue("reset_out", {4'h0, outBus}, 8'h08);
        compareValue("reset_lock", {7'h0, hmastlock}, 8'h00);
        compareValue("reset_cnt", dut.tenureCount, 8'd0);

        for (int i = 0; i < 31; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
            checkOutput();
        end

        // Master 2 takes the bus and is mid-burst when reset hits between clock edges.
        driveBus(1'b0, 1'b1, HTRANS_IDLE, 1'b1);
        driveBus(1'b0, 1'b1, HTRANS_NONSEQ, 1'b1);
        driveBus(1'b0, 1'b1, HTRANS_SEQ, 1'b1);
        @(posedge hclk);
        #1;
        compareValue("preReset_out", {4'h0, outBus}, 8'h07);
        @(negedge hclk);
        #2;
        hreset = 1'b1;
        #1;
        compareValue("asyncReset_out", {4'h0, outBus}, 8'h08);
        compareValue("asyncReset_cnt", dut.tenureCount, 8'd0);
        compareValue("asyncReset_lock", {7'h0, hmastlock}, 8'h00);
        @(negedge hclk);
        hreset = 1'b0;
        hbusreq_2 = 1'b0;
        htrans = HTRANS_IDLE;

`ifdef AHB_ARB_LOCK_EN
        doReset();
        hlock_2 = 1'b1;
        driveBus(1'b0, 1'b1, HTRANS_IDLE, 1'b1);
        @(posedge hclk);
        #1;
        compareValue("lockGrant_g2", {7'h0, hgrant_2}, 8'h01);
        for (int i = 0; i < 10; i++) begin
            driveBus(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1);
            @(posedge hclk);
            #1;
            compareValue($sformatf("lockHold%0d_g2", i), {7'h0, hgrant_2}, 8'h01);
            compareValue($sformatf("lockHold%0d_mastlock", i), {7'h0, hmastlock}, 8'h01);
        end
        hlock_2 = 1'b0;
        driveBus(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1);
        @(posedge hclk);
        #1;
        compareValue("lockRelease_g1", {7'h0, hgrant_1}, 8'h01);
        hbusreq_1 = 1'b0;
        hbusreq_2 = 1'b0;
`else
        doReset();
`endif

        compareValue("final_scoreboard_empty", 8'(expQ.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
